seq_alu: RTL

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/seq_alu.sv | 254 +++++++++++++++++++++++++
 1 files changed

// File: rtl/seq_alu.sv
// ============================================================================
//  Module      : seq_alu
//  Description : Sequential ALU. Single-cycle logic/arith/shift ops, radix-2
//                Booth multiplier (WIDTH steps) and signed non-restoring
//                divider (WIDTH steps + one fix-up cycle).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_alu #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [3:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_lo_o,
    output logic [WIDTH-1:0] result_hi_o,
    output logic             div_zero_o
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);

    localparam logic [3:0] OP_OR  = 4'd0;
    localparam logic [3:0] OP_AND = 4'd1;
    localparam logic [3:0] OP_NOT = 4'd2;
    localparam logic [3:0] OP_ADD = 4'd3;
    localparam logic [3:0] OP_SUB = 4'd4;
    localparam logic [3:0] OP_NEG = 4'd5;
    localparam logic [3:0] OP_MUL = 4'd6;
    localparam logic [3:0] OP_DIV = 4'd7;
    localparam logic [3:0] OP_SHL = 4'd8;
    localparam logic [3:0] OP_SHR = 4'd9;
    localparam logic [3:0] OP_SAR = 4'd10;
    localparam logic [3:0] OP_ROL = 4'd11;
    localparam logic [3:0] OP_ROR = 4'd12;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        EXEC    = 3'd1,
        MUL     = 3'd2,
        DIV     = 3'd3,
        DIV_FIX = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t           state_q;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    // acc_q: Booth partial-product high part, or divider partial remainder
    logic [WIDTH:0]   acc_q;
    // qr_q: Booth multiplier bits, or dividend/quotient shift register
    logic [WIDTH-1:0] qr_q;
    // mcand_q: sign-extended multiplicand, or zero-extended divisor magnitude
    logic [WIDTH:0]   mcand_q;
    logic             bk_q;
    logic [CW-1:0]    cnt_q;
    logic             neg_quo_q;
    logic             neg_rem_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] res_lo_q;
    logic [WIDTH-1:0] res_hi_q;
    logic             dz_q;

    logic [WIDTH-1:0]   a_abs_d;
    logic [WIDTH-1:0]   b_abs_d;
    logic [SHW-1:0]     sh_d;
    logic [2*WIDTH-1:0] rol_d;
    logic [2*WIDTH-1:0] ror_d;
    logic [WIDTH-1:0]   exec_lo_d;
    logic [WIDTH-1:0]   exec_hi_d;
    logic [WIDTH:0]     booth_sum_d;
    logic [WIDTH:0]     mul_acc_d;
    logic [WIDTH-1:0]   mul_q_d;
    logic               mul_bk_d;
    logic [WIDTH+1:0]   div_sh_d;
    logic [WIDTH+1:0]   div_new_d;
    logic [WIDTH:0]     div_acc_d;
    logic [WIDTH-1:0]   div_q_d;
    logic [WIDTH-1:0]   rem_mag_d;
    logic [WIDTH-1:0]   quo_out_d;
    logic [WIDTH-1:0]   rem_out_d;

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign result_lo_o = res_lo_q;
    assign result_hi_o = res_hi_q;
    assign div_zero_o  = dz_q;

    // Operand magnitudes for the divider; the most-negative value maps to
    // itself, which is its correct unsigned magnitude.
    always_comb begin
        a_abs_d = a_i[WIDTH-1] ? -a_i : a_i;
        b_abs_d = b_i[WIDTH-1] ? -b_i : b_i;
    end

    // Single-cycle operations; op 7 only reaches EXEC when dividing by zero.
    always_comb begin
        sh_d  = b_q[SHW-1:0];
        rol_d = {a_q, a_q} << sh_d;
        ror_d = {a_q, a_q} >> sh_d;
        exec_hi_d = (op_q == OP_DIV) ? a_q : '0;
        case (op_q)
            OP_OR:   exec_lo_d = a_q | b_q;
            OP_AND:  exec_lo_d = a_q & b_q;
            OP_NOT:  exec_lo_d = ~a_q;
            OP_ADD:  exec_lo_d = a_q + b_q;
            OP_SUB:  exec_lo_d = a_q - b_q;
            OP_NEG:  exec_lo_d = -a_q;
            OP_DIV:  exec_lo_d = '1;
            OP_SHL:  exec_lo_d = a_q << sh_d;
            OP_SHR:  exec_lo_d = a_q >> sh_d;
            OP_SAR:  exec_lo_d = $signed(a_q) >>> sh_d;
            OP_ROL:  exec_lo_d = rol_d[2*WIDTH-1:WIDTH];
            OP_ROR:  exec_lo_d = ror_d[WIDTH-1:0];
            default: exec_lo_d = a_q & b_q;
        endcase
    end

    // One Booth recode/add step followed by an arithmetic right shift of
    // {acc, qr, bk}; acc carries a guard bit so subtracting the most-negative
    // multiplicand cannot overflow.
    always_comb begin
        case ({qr_q[0], bk_q})
            2'b01:   booth_sum_d = acc_q + mcand_q;
            2'b10:   booth_sum_d = acc_q - mcand_q;
            default: booth_sum_d = acc_q;
        endcase
        mul_acc_d = {booth_sum_d[WIDTH], booth_sum_d[WIDTH:1]};
        mul_q_d   = {booth_sum_d[0], qr_q[WIDTH-1:1]};
        mul_bk_d  = qr_q[0];
    end

    // One non-restoring division step plus the final restore/sign fix-up.
    always_comb begin
        div_sh_d = {acc_q, qr_q[WIDTH-1]};
        if (acc_q[WIDTH]) begin
            div_new_d = div_sh_d + {1'b0, mcand_q};
        end else begin
            div_new_d = div_sh_d - {1'b0, mcand_q};
        end
        div_acc_d = div_new_d[WIDTH:0];
        div_q_d   = {qr_q[WIDTH-2:0], ~div_new_d[WIDTH+1]};
        // The restored remainder lies in [0, divisor), so low-word math suffices
        rem_mag_d = acc_q[WIDTH] ? (acc_q[WIDTH-1:0] + mcand_q[WIDTH-1:0])
                                 : acc_q[WIDTH-1:0];
        quo_out_d = neg_quo_q ? -qr_q : qr_q;
        rem_out_d = neg_rem_q ? -rem_mag_d : rem_mag_d;
    end

    // Control FSM, iteration datapath and registered result outputs.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            qr_q      <= '0;
            mcand_q   <= '0;
            bk_q      <= 1'b0;
            cnt_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            res_lo_q  <= '0;
            res_hi_q  <= '0;
            dz_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        busy_q    <= 1'b1;
                        dz_q      <= 1'b0;
                        op_q      <= op_i;
                        a_q       <= a_i;
                        b_q       <= b_i;
                        acc_q     <= '0;
                        bk_q      <= 1'b0;
                        cnt_q     <= CNT_INIT;
                        neg_quo_q <= a_i[WIDTH-1] ^ b_i[WIDTH-1];
                        neg_rem_q <= a_i[WIDTH-1];
                        if (op_i == OP_MUL) begin
                            qr_q    <= b_i;
                            mcand_q <= {a_i[WIDTH-1], a_i};
                            state_q <= MUL;
                        end else if ((op_i == OP_DIV) && (b_i != '0)) begin
                            qr_q    <= a_abs_d;
                            mcand_q <= {1'b0, b_abs_d};
                            state_q <= DIV;
                        end else begin
                            state_q <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    res_lo_q <= exec_lo_d;
                    res_hi_q <= exec_hi_d;
                    dz_q     <= (op_q == OP_DIV);
                    done_q   <= 1'b1;
                    state_q  <= DONE;
                end
                MUL: begin
                    acc_q <= mul_acc_d;
                    qr_q  <= mul_q_d;
                    bk_q  <= mul_bk_d;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        res_lo_q <= mul_q_d;
                        res_hi_q <= mul_acc_d[WIDTH-1:0];
                        done_q   <= 1'b1;
                        state_q  <= DONE;
                    end
                end
                DIV: begin
                    acc_q <= div_acc_d;
                    qr_q  <= div_q_d;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        state_q <= DIV_FIX;
                    end
                end
                DIV_FIX: begin
                    res_lo_q <= quo_out_d;
                    res_hi_q <= rem_out_d;
                    done_q   <= 1'b1;
                    state_q  <= DONE;
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
